mem_mc_arb: RTL and testbench
=============================

Name: mem_mc_arb

Overview:
- Parametrised multi-channel successor to the single-port lab memory `mem`.
- NUM_CH requesters share one 2**ADDR_WIDTH x DATA_WIDTH storage array.
- A round-robin arbiter grants one request per cycle over a valid/ready handshake.
- Read data returns through a fixed-latency pipeline, tagged to the requesting channel; sits where `mem` sat, behind the bench/test driver.

Parameters:
- NUM_CH, 2: number of requester channels (>=1).
- ADDR_WIDTH, 5: address width; array depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: data word width.
- READ_LATENCY, 2: cycles from read handshake edge to response (>=1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_CH  per-channel request valid.
- req_ready  output  NUM_CH  per-channel grant; at most one bit high.
- req_write  input  NUM_CH  per-channel op: 1 = write, 0 = read.
- req_addr  input  NUM_CH*ADDR_WIDTH  channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_CH*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  output  NUM_CH  one-hot (or zero) read-response strobe.
- rsp_data  output  DATA_WIDTH  read data, qualified by rsp_valid.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset assertion (async):
  - rsp_valid = 0, rsp_data = 0.
  - Arbiter pointer ptr = 0.
  - Read pipeline flushed; in-flight reads are dropped and never respond.
  - req_ready forced to 0 while reset is high.
  - Storage contents NOT cleared (undefined until written).
- Handshake:
  - Transfer on channel i occurs at a rising edge where req_valid[i] && req_ready[i].
  - A requester holds valid/write/addr/wdata stable until the transfer.
  - req_ready is combinational from req_valid and ptr; there is no other stall source.
- Arbitration, round-robin:
  - Scan channels ptr, ptr+1, ..., wrapping mod NUM_CH; the first with req_valid high gets req_ready.
  - On transfer: ptr <= (granted index + 1) mod NUM_CH.
  - No request: ptr holds.
  - NUM_CH=1: ready = valid.
- Write: mem[addr] <= wdata at the transfer edge; no response is generated.
- Read:
  - Array sampled at the transfer edge, returning the pre-edge contents.
  - rsp_valid[i] is high for exactly 1 cycle, READ_LATENCY cycles after the transfer edge.
  - rsp_data is valid in that same cycle.
- Pipelining: fully pipelined; a new read may transfer every cycle, and responses emerge in grant order, one per cycle max.
- rsp_data when no rsp_valid bit is set: 0.
- Read-after-write: a write at edge t followed by a read of the same address at edge t+1 returns the new data. Same-edge write+read is impossible (single grant).
- Addresses: all ADDR_WIDTH values are legal (depth = 2**ADDR_WIDTH); no out-of-range case exists.
- Mid-operation reset: deassertion resumes with ptr = 0 and an empty pipeline; requesters must re-issue any unanswered reads.

Test Plan (NUM_CH=2, ADDR_WIDTH=5, DATA_WIDTH=8, READ_LATENCY=2):
- Single channel:
  - Stimulus: ch0 writes 0xA5 to addr 3, then reads addr 3.
  - Response: req_ready[0] = 1 each request; rsp_valid = 2'b01 with rsp_data = 0xA5 exactly 2 cycles after the read edge; rsp_data = 0 otherwise.
- Contention:
  - Stimulus: ch0 and ch1 both hold valid reads (addr 1 = 0x11, addr 2 = 0x22) for 4 cycles after reset.
  - Response: grants alternate ch0, ch1, ch0, ch1; responses alternate 2'b01/0x11 and 2'b10/0x22, one per cycle.
- Back-to-back:
  - Stimulus: ch1 writes 0x5C to addr 31 at edge t, then reads addr 31 at edge t+1.
  - Response: rsp_valid = 2'b10, rsp_data = 0x5C in the cycle after edge t+3.
- Throughput:
  - Stimulus: ch0 issues reads of addrs 0..31 on consecutive cycles, with mem[k] = k^8'hFF preloaded.
  - Response: 32 consecutive cycles of rsp_valid = 2'b01 with correct data, no gaps.
- Reset mid-flight:
  - Stimulus: a read of addr 4 is transferred, then reset is pulsed 1 cycle later.
  - Response: rsp_valid never asserts for that read; after deassertion, with both channels valid, ch0 is granted first (ptr = 0); addr 4 still holds its pre-reset value.
- Idle pointer:
  - Stimulus: ch1 is granted, then 3 idle cycles, then both channels request.
  - Response: ch0 is granted first (ptr holds at 0 while idle).

Source files
------------

// File: rtl/mem_mc_arb.sv
// mem_mc_arb: NUM_CH requesters share one 2**ADDR_WIDTH x DATA_WIDTH array.
// A round-robin arbiter grants at most one request per cycle. Reads return
// through a fixed-latency pipeline with a one-hot strobe naming the channel.
module mem_mc_arb #(
  parameter int NUM_CH       = 2,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_CH-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Stage 0 is loaded at the read handshake edge; stage READ_LATENCY drives
  // the response, so the strobe appears READ_LATENCY edges after the transfer.
  logic [NUM_CH-1:0]     pipe_vld_q  [READ_LATENCY+1];
  logic [NUM_CH-1:0]     pipe_vld_d  [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0] pipe_data_q [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0] pipe_data_d [READ_LATENCY+1];

  logic [NUM_CH-1:0]     rot;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_CH-1:0]     grant;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin pick: rotate valids so the pointer channel sits at bit 0,
  // take the first set bit, map it back to a channel index.
  always_comb begin
    rot       = NUM_CH'({req_valid, req_valid} >> ptr_q);
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'((int'(ptr_q) + k) % NUM_CH);
      end
    end
    // No grants while reset is held, so nothing transfers into the array.
    if (reset) grant_any = 1'b0;
    grant     = grant_any ? (NUM_CH'(1) << grant_idx) : '0;
    req_ready = grant;
  end

  // Mux out the granted channel's request and advance the pointer past it.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_write = req_write[c];
        sel_addr  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (grant_any) ptr_d = PTR_W'((int'(grant_idx) + 1) % NUM_CH);
  end

  // Read pipeline next state: capture pre-edge array contents on a read grant.
  always_comb begin
    pipe_vld_d[0]  = (grant_any && !sel_write) ? grant : '0;
    pipe_data_d[0] = mem_q[sel_addr];
    for (int s = 1; s <= READ_LATENCY; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_data_d[s] = pipe_data_q[s-1];
    end
  end

  // Control state: pointer and response strobes, flushed by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      pipe_vld_q <= '{default: '0};
    end else begin
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Datapath state: storage array and read data, never reset.
  always_ff @(posedge clk) begin
    pipe_data_q <= pipe_data_d;
    if (grant_any && sel_write) mem_q[sel_addr] <= sel_wdata;
  end

  assign rsp_valid = pipe_vld_q[READ_LATENCY];
  assign rsp_data  = (|pipe_vld_q[READ_LATENCY]) ? pipe_data_q[READ_LATENCY] : '0;

endmodule

// File: tb/tb_mem_mc_arb.sv
// Testbench for mem_mc_arb (NUM_CH=2, ADDR_WIDTH=5, DATA_WIDTH=8, READ_LATENCY=2).
// A transaction-level model (reference array, pointer, queue of due responses)
// predicts grants and responses; scenario tasks also check fixed expectations.
module tb_mem_mc_arb;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = '0;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    int         ch;
    logic [7:0] data;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] ref_mem [32];
  int         ref_ptr = 0;

  mem_mc_arb #(.NUM_CH(2), .ADDR_WIDTH(5), .DATA_WIDTH(8), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int c, input logic v, input logic w,
                         input int a, input logic [7:0] d);
    req_valid[c]          = v;
    req_write[c]          = w;
    req_addr[c*5 +: 5]    = a[4:0];
    req_wdata[c*8 +: 8]   = d;
  endtask

  task automatic new_req(input int c);
    int a;
    a = $urandom_range(0, 7);
    set_req(c, 1'b1, ($urandom_range(0, 2) == 0), a, 8'($urandom));
  endtask

  // One clock cycle: predict the grant from the rules, sample req_ready at
  // the falling edge, apply the transfer to the model at the rising edge,
  // then sample the response 1 time unit later. Returns {ready,rsp_valid,rsp_data}.
  task automatic advance(output logic [11:0] exp_t, output logic [11:0] got_t);
    logic [1:0] er, ev, got_rdy;
    logic [7:0] ed;
    logic [4:0] a;
    int g;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (reset) begin
      exp_q.delete();
      ref_ptr = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (ref_ptr + k) % 2;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    got_rdy = req_ready;
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      ref_ptr = (g + 1) % 2;
      a = req_addr[g*5 +: 5];
      if (req_write[g]) ref_mem[a] = req_wdata[g*8 +: 8];
      else exp_q.push_back('{due: cyc + LAT, ch: g, data: ref_mem[a]});
    end
    #1;
    ev = '0;
    ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev[exp_q[0].ch] = 1'b1;
      ed = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    exp_t = {er, ev, ed};
    got_t = {got_rdy, rsp_valid, rsp_data};
  endtask

  task automatic test_reset();
    logic [11:0] e, g;
    req_valid = 2'b11;
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", {req_ready, rsp_valid, rsp_data}, 12'h000);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_edge got=%h exp=%h", {req_ready, rsp_valid, rsp_data}, 12'h000);
    end
    reset = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    ref_ptr = 0;
    advance(e, g);
    checks++;
    if (g !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", g, 12'h000);
    end
  endtask

  task automatic test_single();
    logic [11:0] e, g;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) set_req(0, 1'b1, 1'b1, 3, 8'hA5);
      else if (j == 1) set_req(0, 1'b1, 1'b0, 3, 8'h00);
      else set_req(0, 1'b0, 1'b0, 0, 8'h00);
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j < 2) begin
        checks++;
        if (g[11:10] !== 2'b01) begin
          errors++;
          $display("FAIL single_ready cyc=%0d got=%b exp=01", cyc, g[11:10]);
        end
      end else begin
        checks++;
        if (g[9:0] !== ((j == 3) ? {2'b01, 8'hA5} : 10'h000)) begin
          errors++;
          $display("FAIL single_rsp j=%0d got=%h", j, g[9:0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [11:0] e, g;
    logic [9:0]  want;
    set_req(0, 1'b1, 1'b1, 1, 8'h11); advance(e, g);
    set_req(0, 1'b1, 1'b1, 2, 8'h22); advance(e, g);
    set_req(0, 1'b0, 1'b0, 0, 8'h00);
    reset = 1'b1;
    advance(e, g);
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 1, 8'h00);
    set_req(1, 1'b1, 1'b0, 2, 8'h00);
    for (int j = 0; j < 8; j++) begin
      if (j == 4) req_valid = 2'b00;
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j < 4) begin
        checks++;
        if (g[11:10] !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL contention_grant j=%0d got=%b", j, g[11:10]);
        end
      end
      if (j >= 2 && j < 6) begin
        want = ((j - 2) % 2 == 0) ? {2'b01, 8'h11} : {2'b10, 8'h22};
        checks++;
        if (g[9:0] !== want) begin
          errors++;
          $display("FAIL contention_rsp j=%0d got=%h exp=%h", j, g[9:0], want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, g;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) set_req(1, 1'b1, 1'b1, 31, 8'h5C);
      else if (j == 1) set_req(1, 1'b1, 1'b0, 31, 8'h00);
      else set_req(1, 1'b0, 1'b0, 0, 8'h00);
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j == 3) begin
        checks++;
        if (g[9:0] !== {2'b10, 8'h5C}) begin
          errors++;
          $display("FAIL b2b_rsp got=%h exp=%h", g[9:0], {2'b10, 8'h5C});
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic [11:0] e, g;
    int seen;
    for (int k = 0; k < 32; k++) begin
      set_req(0, 1'b1, 1'b1, k, 8'(k) ^ 8'hFF);
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL preload cyc=%0d got=%h exp=%h", cyc, g, e);
      end
    end
    seen = 0;
    for (int j = 0; j < 34; j++) begin
      if (j < 32) set_req(0, 1'b1, 1'b0, j, 8'h00);
      else set_req(0, 1'b0, 1'b0, 0, 8'h00);
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL throughput cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j >= 2 && g[9:0] === {2'b01, 8'(j - 2) ^ 8'hFF}) seen++;
    end
    checks++;
    if (seen != 32) begin
      errors++;
      $display("FAIL throughput_count got=%0d exp=32", seen);
    end
  endtask

  task automatic test_reset_midflight();
    logic [11:0] e, g;
    for (int j = 0; j < 5; j++) begin
      reset = 1'b0;
      case (j)
        0: set_req(0, 1'b1, 1'b0, 4, 8'h00);
        1: begin set_req(0, 1'b0, 1'b0, 0, 8'h00); reset = 1'b1; end
        2: begin set_req(0, 1'b1, 1'b0, 4, 8'h00); set_req(1, 1'b1, 1'b0, 5, 8'h00); end
        3: set_req(0, 1'b0, 1'b0, 0, 8'h00);
        default: set_req(1, 1'b0, 1'b0, 0, 8'h00);
      endcase
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL midflight cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j == 1 || j == 2) begin
        checks++;
        if (g[11:10] !== ((j == 1) ? 2'b00 : 2'b01) || g[9:8] !== 2'b00) begin
          errors++;
          $display("FAIL midflight_drop j=%0d got=%h", j, g);
        end
      end
      if (j == 4) begin
        checks++;
        if (g[9:0] !== {2'b01, 8'hFB}) begin
          errors++;
          $display("FAIL midflight_keep got=%h exp=%h", g[9:0], {2'b01, 8'hFB});
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_ptr();
    logic [11:0] e, g;
    for (int j = 0; j < 9; j++) begin
      if (j == 0) set_req(1, 1'b1, 1'b0, 31, 8'h00);
      else if (j == 4) begin set_req(0, 1'b1, 1'b0, 0, 8'h00); set_req(1, 1'b1, 1'b0, 31, 8'h00); end
      else req_valid = 2'b00;
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL idle_ptr cyc=%0d got=%h exp=%h", cyc, g, e);
      end
      if (j == 0 || j == 4) begin
        checks++;
        if (g[11:10] !== ((j == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL idle_ptr_grant j=%0d got=%b", j, g[11:10]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e, g;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 2; c++)
        if (!req_valid[c] && $urandom_range(0, 1) == 1) new_req(c);
      reset = ($urandom_range(0, 49) == 0);
      advance(e, g);
      reset = 1'b0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random i=%0d cyc=%0d got=%h exp=%h", i, cyc, g, e);
      end
      for (int c = 0; c < 2; c++) begin
        if (e[10 + c]) begin
          if ($urandom_range(0, 3) != 0) new_req(c);
          else req_valid[c] = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      advance(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_throughput();
    test_reset_midflight();
    test_idle_ptr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
